alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//   8-bit registered ALU for the pipelined CPU execute stage.
//   Performs add/sub, logic, shift, compare and input-port pass-through
//   selected by a 4-bit function code. Produces a result plus C/Z/V/N flags.
//   All outputs are registered: one cycle of latency from inputs to outputs.
// PARAMETERS
//   none (datapath fixed at 8 bits, shift amount fixed at 3 bits)
// PORTS
//   clk              in   1  clock, all state updates on rising edge
//   rst              in   1  synchronous, active-high reset
//   A                in   8  operand A (two's complement for signed ops)
//   B                in   8  operand B
//   input_port_data  in   8  external data port value
//   input_port_kb    in   8  keyboard port value
//   function_select  in   4  operation code (table below)
//   shift            in   3  shift amount 0..7 for SL/SR
//   F                out  8  registered result
//   C                out  1  registered carry/borrow/shift-out flag
//   Z                out  1  registered zero flag
//   V                out  1  registered signed-overflow flag
//   N                out  1  registered negative flag
// BEHAVIOUR
// - One clock; reset is synchronous, active-high (rst sampled on rising clk).
// - On rst=1 at a clock edge: F=8'h00, C=Z=V=N=0. Reset overrides operation.
// - Otherwise every edge registers the combinational result of the current inputs.
//   Latency exactly 1 cycle, no handshake, new op accepted every cycle.
// - Opcodes (R = next F):
//   0000 ADD: R=A+B; C=carry out of bit 7; V=(A7==B7)&&(R7!=A7).
//   0001 SUB: R=A-B; C=borrow (1 iff A<B unsigned); V=(A7!=B7)&&(R7!=A7).
//   0010 AND: R=A&B.  0011 OR: R=A|B.  0100 XOR: R=A^B.  0101 NOT: R=~A.
//   0110 SL : R=A<<shift (logical, zero fill); C=last bit shifted out
//             (A[8-shift]); shift=0 -> R=A, C=0.
//   0111 CMP: R=8'h01 if A<B (signed), else 8'h00; Z=(A==B);
//             C,V as for SUB of A-B; N=sign of A-B.
//   1000 SR : R=A>>shift (logical, zero fill); C=A[shift-1]; shift=0 -> R=A, C=0.
//   1001 IND: R=input_port_data.  1010 INK: R=input_port_kb.
//   1011 PASSA: R=A.  1100 PASSB: R=B.
//   1101..1111: R=8'h00, all flags 0.
// - Flags for ops other than ADD/SUB/CMP/SL/SR: C=0, V=0.
// - Z=(R==0) and N=R[7] for all ops except CMP (defined above) and 1101..1111.
// - Arithmetic wraps modulo 256; no saturation.
// - Mid-operation reset: rst has priority in the cycle it is asserted; the
//   first op after release is registered on the first edge with rst=0.
// TESTING
// - Reset: rst=1 for 2 edges with A=B=8'hFF, op ADD -> F=00, C=Z=V=N=0.
// - ADD: A=0F,B=0F -> F=1E,C=0,V=0,Z=0,N=0; A=F0,B=F0 -> F=E0,C=1,V=0,N=1;
//   A=7F,B=01 -> F=80,V=1,N=1.
// - SUB: A=0F,B=07 -> F=08,C=0; A=F0,B=F8 -> F=F8,C=1,N=1; A=80,B=01 -> F=7F,V=1.
// - Logic: AND 5B&4B -> 4B; OR DB|4F -> DF; XOR CA^4D -> 87; NOT 4E -> B1.
// - Shifts: SL A=0F,sh=1 -> 1E; sh=3 -> 78; SR A=F0,sh=1 -> 78,C=0;
//   sh=3 -> 1E; SL A=80,sh=1 -> F=00,C=1,Z=1.
// - CMP: 00,00 -> Z=1,F=00; 00,01 -> Z=0,F=01; 0F,07 -> F=00; 07,0F -> F=01;
//   ports: op 1001 with data=A5 -> F=A5,N=1; op 1010 kb=00 -> Z=1.
//   Verify each result appears exactly one edge after inputs are applied.

Source files
------------

// File: rtl/alu_core.sv
// 8-bit registered ALU for the execute stage: add/sub, logic, shifts, compare and
// port pass-through selected by function_select, with C/Z/V/N flags, one cycle latency.
module alu_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic [7:0] input_port_data,
    input  logic [7:0] input_port_kb,
    input  logic [3:0] function_select,
    input  logic [2:0] shift,
    output logic [7:0] F,
    output logic       C,
    output logic       Z,
    output logic       V,
    output logic       N
);

    localparam int unsigned DW = 8;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_NOT   = 4'h5;
    localparam logic [3:0] OP_SL    = 4'h6;
    localparam logic [3:0] OP_CMP   = 4'h7;
    localparam logic [3:0] OP_SR    = 4'h8;
    localparam logic [3:0] OP_IND   = 4'h9;
    localparam logic [3:0] OP_INK   = 4'hA;
    localparam logic [3:0] OP_PASSA = 4'hB;
    localparam logic [3:0] OP_PASSB = 4'hC;

    logic [DW:0]   w_sum;
    logic [DW:0]   w_diff;
    logic [DW:0]   w_sl;
    logic [DW:0]   w_sr;
    logic          w_add_v;
    logic          w_sub_v;
    logic          w_lt_s;
    logic [DW-1:0] w_res;
    logic          w_c;
    logic          w_z;
    logic          w_v;
    logic          w_n;

    // Ninth bit of sum/diff is carry-out and unsigned borrow respectively.
    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} - {1'b0, B};
    assign w_add_v = (A[DW-1] == B[DW-1]) && (w_sum[DW-1] != A[DW-1]);
    assign w_sub_v = (A[DW-1] != B[DW-1]) && (w_diff[DW-1] != A[DW-1]);
    assign w_lt_s  = (A[DW-1] ^ B[DW-1]) ? A[DW-1] : w_diff[DW-1];

    // One spare bit catches the last bit shifted out; it is zero when shift is 0.
    assign w_sl = {1'b0, A} << shift;
    assign w_sr = {A, 1'b0} >> shift;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (function_select)
            OP_ADD:   begin w_res = w_sum[DW-1:0];  w_c = w_sum[DW];  w_v = w_add_v; end
            OP_SUB:   begin w_res = w_diff[DW-1:0]; w_c = w_diff[DW]; w_v = w_sub_v; end
            OP_AND:   w_res = A & B;
            OP_OR:    w_res = A | B;
            OP_XOR:   w_res = A ^ B;
            OP_NOT:   w_res = ~A;
            OP_SL:    begin w_res = w_sl[DW-1:0]; w_c = w_sl[DW]; end
            OP_CMP:   begin w_res = DW'(w_lt_s);  w_c = w_diff[DW]; w_v = w_sub_v; end
            OP_SR:    begin w_res = w_sr[DW:1];   w_c = w_sr[0]; end
            OP_IND:   w_res = input_port_data;
            OP_INK:   w_res = input_port_kb;
            OP_PASSA: w_res = A;
            OP_PASSB: w_res = B;
            default:  w_res = '0;
        endcase

        // Compare reports equality and the sign of A-B rather than of its 0/1 result.
        w_z = (w_res == '0);
        w_n = w_res[DW-1];
        if (function_select == OP_CMP) begin
            w_z = (A == B);
            w_n = w_diff[DW-1];
        end else if (function_select > OP_PASSB) begin
            w_z = 1'b0;
            w_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            F <= '0;
            C <= 1'b0;
            Z <= 1'b0;
            V <= 1'b0;
            N <= 1'b0;
        end else begin
            F <= w_res;
            C <= w_c;
            Z <= w_z;
            V <= w_v;
            N <= w_n;
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Directed self-checking bench for alu_core: hand-computed result/flag vectors,
// reset behaviour and one-cycle latency.
`timescale 1ns/1ps
module tb_alu_core;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] input_port_data;
    logic [7:0] input_port_kb;
    logic [3:0] function_select;
    logic [2:0] shift;
    logic [7:0] F;
    logic       C;
    logic       Z;
    logic       V;
    logic       N;

    int checks;
    int failures;

    // Expected flags packed as {C,Z,V,N}.
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sh;
        logic [7:0] f;
        logic [3:0] flg;
    } vec_t;

    alu_core dut (
        .clk             (clk),
        .rst             (rst),
        .A               (A),
        .B               (B),
        .input_port_data (input_port_data),
        .input_port_kb   (input_port_kb),
        .function_select (function_select),
        .shift           (shift),
        .F               (F),
        .C               (C),
        .Z               (Z),
        .V               (V),
        .N               (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs at the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sh);
        @(negedge clk);
        function_select = op;
        A = a;
        B = b;
        shift = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        A = 8'hFF;
        B = 8'hFF;
        function_select = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({F, C, Z, V, N} !== 12'h000) begin
            failures++;
            $display("FAIL reset got F=%h CZVN=%b%b%b%b exp F=00 CZVN=0000", F, C, Z, V, N);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({F, C, Z, V, N} !== {8'hFE, 4'b1001}) begin
            failures++;
            $display("FAIL reset_release got F=%h CZVN=%b%b%b%b exp F=fe CZVN=1001", F, C, Z, V, N);
        end
    endtask

    task automatic test_arith();
        vec_t v[6] = '{
            '{4'h0, 8'h0F, 8'h0F, 3'd0, 8'h1E, 4'b0000},
            '{4'h0, 8'hF0, 8'hF0, 3'd0, 8'hE0, 4'b1001},
            '{4'h0, 8'h7F, 8'h01, 3'd0, 8'h80, 4'b0011},
            '{4'h1, 8'h0F, 8'h07, 3'd0, 8'h08, 4'b0000},
            '{4'h1, 8'hF0, 8'hF8, 3'd0, 8'hF8, 4'b1001},
            '{4'h1, 8'h80, 8'h01, 3'd0, 8'h7F, 4'b0010}
        };
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].sh);
            checks++;
            if ({F, C, Z, V, N} !== {v[i].f, v[i].flg}) begin
                failures++;
                $display("FAIL arith[%0d] got F=%h CZVN=%b%b%b%b exp F=%h CZVN=%b",
                         i, F, C, Z, V, N, v[i].f, v[i].flg);
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[6] = '{
            '{4'h2, 8'h5B, 8'h4B, 3'd0, 8'h4B, 4'b0000},
            '{4'h3, 8'hDB, 8'h4F, 3'd0, 8'hDF, 4'b0001},
            '{4'h4, 8'hCA, 8'h4D, 3'd0, 8'h87, 4'b0001},
            '{4'h5, 8'h4E, 8'h00, 3'd0, 8'hB1, 4'b0001},
            '{4'h2, 8'hF0, 8'h0F, 3'd0, 8'h00, 4'b0100},
            '{4'h5, 8'hFF, 8'h00, 3'd0, 8'h00, 4'b0100}
        };
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].sh);
            checks++;
            if ({F, C, Z, V, N} !== {v[i].f, v[i].flg}) begin
                failures++;
                $display("FAIL logic[%0d] got F=%h CZVN=%b%b%b%b exp F=%h CZVN=%b",
                         i, F, C, Z, V, N, v[i].f, v[i].flg);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[9] = '{
            '{4'h6, 8'h0F, 8'h00, 3'd1, 8'h1E, 4'b0000},
            '{4'h6, 8'h0F, 8'h00, 3'd3, 8'h78, 4'b0000},
            '{4'h8, 8'hF0, 8'h00, 3'd1, 8'h78, 4'b0000},
            '{4'h8, 8'hF0, 8'h00, 3'd3, 8'h1E, 4'b0000},
            '{4'h6, 8'h80, 8'h00, 3'd1, 8'h00, 4'b1100},
            '{4'h6, 8'h81, 8'h00, 3'd0, 8'h81, 4'b0001},
            '{4'h8, 8'h81, 8'h00, 3'd0, 8'h81, 4'b0001},
            '{4'h8, 8'h01, 8'h00, 3'd1, 8'h00, 4'b1100},
            '{4'h6, 8'hFF, 8'h00, 3'd7, 8'h80, 4'b1001}
        };
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].sh);
            checks++;
            if ({F, C, Z, V, N} !== {v[i].f, v[i].flg}) begin
                failures++;
                $display("FAIL shift[%0d] got F=%h CZVN=%b%b%b%b exp F=%h CZVN=%b",
                         i, F, C, Z, V, N, v[i].f, v[i].flg);
            end
        end
    endtask

    task automatic test_cmp();
        vec_t v[6] = '{
            '{4'h7, 8'h00, 8'h00, 3'd0, 8'h00, 4'b0100},
            '{4'h7, 8'h00, 8'h01, 3'd0, 8'h01, 4'b1001},
            '{4'h7, 8'h0F, 8'h07, 3'd0, 8'h00, 4'b0000},
            '{4'h7, 8'h07, 8'h0F, 3'd0, 8'h01, 4'b1001},
            '{4'h7, 8'h80, 8'h01, 3'd0, 8'h01, 4'b0010},
            '{4'h7, 8'h01, 8'hFF, 3'd0, 8'h00, 4'b1000}
        };
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].sh);
            checks++;
            if ({F, C, Z, V, N} !== {v[i].f, v[i].flg}) begin
                failures++;
                $display("FAIL cmp[%0d] got F=%h CZVN=%b%b%b%b exp F=%h CZVN=%b",
                         i, F, C, Z, V, N, v[i].f, v[i].flg);
            end
        end
    endtask

    task automatic test_ports();
        vec_t v[6] = '{
            '{4'h9, 8'h00, 8'h00, 3'd0, 8'hA5, 4'b0001},
            '{4'hA, 8'h11, 8'h22, 3'd0, 8'h00, 4'b0100},
            '{4'hB, 8'h3C, 8'hC3, 3'd0, 8'h3C, 4'b0000},
            '{4'hC, 8'h3C, 8'hC3, 3'd0, 8'hC3, 4'b0001},
            '{4'hD, 8'hFF, 8'hFF, 3'd7, 8'h00, 4'b0000},
            '{4'hF, 8'h80, 8'h80, 3'd1, 8'h00, 4'b0000}
        };
        input_port_data = 8'hA5;
        input_port_kb   = 8'h00;
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].sh);
            checks++;
            if ({F, C, Z, V, N} !== {v[i].f, v[i].flg}) begin
                failures++;
                $display("FAIL ports[%0d] got F=%h CZVN=%b%b%b%b exp F=%h CZVN=%b",
                         i, F, C, Z, V, N, v[i].f, v[i].flg);
            end
        end
    endtask

    task automatic test_latency();
        apply(4'h0, 8'h01, 8'h01, 3'd0);
        @(negedge clk);
        function_select = 4'h3;
        A = 8'hA0;
        B = 8'h05;
        #1;
        checks++;
        if (F !== 8'h02) begin
            failures++;
            $display("FAIL latency_hold got F=%h exp F=02", F);
        end
        @(posedge clk);
        #1;
        checks++;
        if (F !== 8'hA5 || N !== 1'b1) begin
            failures++;
            $display("FAIL latency_update got F=%h N=%b exp F=a5 N=1", F, N);
        end
    endtask

    task automatic test_mid_reset();
        apply(4'h0, 8'h10, 8'h20, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        function_select = 4'h0;
        A = 8'h7F;
        B = 8'h7F;
        @(posedge clk);
        #1;
        checks++;
        if ({F, C, Z, V, N} !== 12'h000) begin
            failures++;
            $display("FAIL mid_reset got F=%h CZVN=%b%b%b%b exp F=00 CZVN=0000", F, C, Z, V, N);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({F, C, Z, V, N} !== {8'hFE, 4'b0011}) begin
            failures++;
            $display("FAIL mid_reset_release got F=%h CZVN=%b%b%b%b exp F=fe CZVN=0011",
                     F, C, Z, V, N);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[4] = '{
            '{4'h0, 8'hFF, 8'h01, 3'd0, 8'h00, 4'b1100},
            '{4'h1, 8'h00, 8'h01, 3'd0, 8'hFF, 4'b1001},
            '{4'h4, 8'hAA, 8'hAA, 3'd0, 8'h00, 4'b0100},
            '{4'h8, 8'h80, 8'h00, 3'd7, 8'h01, 4'b0000}
        };
        foreach (v[i]) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].sh);
            checks++;
            if ({F, C, Z, V, N} !== {v[i].f, v[i].flg}) begin
                failures++;
                $display("FAIL b2b[%0d] got F=%h CZVN=%b%b%b%b exp F=%h CZVN=%b",
                         i, F, C, Z, V, N, v[i].f, v[i].flg);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        A = '0;
        B = '0;
        input_port_data = '0;
        input_port_kb = '0;
        function_select = '0;
        shift = '0;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_cmp();
        test_ports();
        test_latency();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
